// File: rtl/comparator_serial_ctrl.sv
// Serial MSB-first magnitude comparator: one bit pair per cycle through a 1-bit slice,
// with valid/ready handshakes on operand capture and result handoff.
module comparator_serial_ctrl #(
  parameter int unsigned WIDTH      = 3,
  parameter bit          EARLY_EXIT = 1'b1,
  localparam int unsigned IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned BW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lesser,
  output logic             greater,
  output logic             equal,
  output logic             busy,
  output logic [BW-1:0]    bits_used
);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_q, lt_d, gt_q, gt_d;
  logic             lesser_q, lesser_d, greater_q, greater_d, equal_q, equal_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             bit_a, bit_b;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    lesser_d  = lesser_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    bits_d    = bits_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(WIDTH - 1);
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          bits_d  = '0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        bits_d = bits_q + 1'b1;
        // Only the most significant difference decides the result.
        if ((bit_a != bit_b) && !lt_q && !gt_q) begin
          lt_d = bit_b;
          gt_d = bit_a;
        end
        if ((EARLY_EXIT && (lt_d || gt_d)) || (idx_q == '0)) begin
          state_d   = StDone;
          lesser_d  = lt_d;
          greater_d = gt_d;
          equal_d   = ~lt_d & ~gt_d;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d   = StIdle;
          lesser_d  = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      lesser_q  <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
      lesser_q  <= lesser_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      bits_q    <= bits_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign lesser    = lesser_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign bits_used = bits_q;

endmodule
